cu_power_sequencer: RTL

Parametrised successor to the fixed-size compute-unit clock/reset controller. It sequences clock-enable and reset for NUM_CUS compute units and the shared L2. Each CU gets its own sleep/wake FSM with retention gating, a drain window with hysteresis, and reset pulse stretching. The L2 is auto-gated when every CU is parked and the L2 reports idle. The block sits between the configuration registers and the clock-gating cells at the GPU top level.

---
 rtl/cu_power_sequencer.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/cu_power_sequencer.sv
// Clock-enable / reset sequencer for NUM_CUS compute units plus the shared L2.
// Latency: start to CU reset release is RST_CYCLES+1 with L2 on, 2*RST_CYCLES+2 from L2 off; outputs registered.
// No backpressure: start is a level that is held until the CU leaves OFF/GATED.
module cu_power_sequencer #(
    parameter int NUM_CUS        = 4,
    parameter int RST_CYCLES     = 4,
    parameter int DRAIN_CYCLES   = 8,
    parameter int L2_IDLE_CYCLES = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_CUS-1:0]     cu_start_i,
    input  logic [NUM_CUS-1:0]     cu_off_i,
    input  logic [NUM_CUS-1:0]     cu_sleep_req_i,
    input  logic [NUM_CUS-1:0]     cu_delay_sleep_i,
    input  logic                   l2_busy_i,
    output logic [NUM_CUS-1:0]     cu_clk_en_o,
    output logic [NUM_CUS-1:0]     cu_rst_n_o,
    output logic [2*NUM_CUS-1:0]   cu_state_o,
    output logic                   l2_clk_en_o,
    output logic                   l2_rst_n_o,
    output logic                   all_idle_o
);

    typedef enum logic [1:0] {
        L2_OFF   = 2'd0,
        L2_RST   = 2'd1,
        L2_ON    = 2'd2,
        L2_GATED = 2'd3
    } l2_state_t;

    typedef enum logic [2:0] {
        CU_OFF   = 3'd0,
        CU_RST   = 3'd1,
        CU_RUN   = 3'd2,
        CU_DRAIN = 3'd3,
        CU_GATED = 3'd4
    } cu_state_t;

    localparam int L2_MAX = (RST_CYCLES > L2_IDLE_CYCLES) ? RST_CYCLES : L2_IDLE_CYCLES;
    localparam int CU_MAX = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
    localparam int L2_CW  = $clog2(L2_MAX + 1);
    localparam int CU_CW  = $clog2(CU_MAX + 1);

    localparam logic [L2_CW-1:0] L2_RST_LAST  = L2_CW'(RST_CYCLES - 1);
    localparam logic [L2_CW-1:0] L2_IDLE_LAST = L2_CW'(L2_IDLE_CYCLES - 1);
    localparam logic [CU_CW-1:0] CU_RST_LAST  = CU_CW'(RST_CYCLES - 1);
    localparam logic [CU_CW-1:0] CU_DRN_LAST  = CU_CW'(DRAIN_CYCLES - 1);

    l2_state_t          l2_state, l2_state_nxt;
    logic [L2_CW-1:0]   l2_cnt, l2_cnt_nxt;
    cu_state_t          cu_state     [NUM_CUS];
    cu_state_t          cu_state_nxt [NUM_CUS];
    logic [CU_CW-1:0]   cu_cnt       [NUM_CUS];
    logic [CU_CW-1:0]   cu_cnt_nxt   [NUM_CUS];

    logic [NUM_CUS-1:0] parked;
    logic [NUM_CUS-1:0] parked_nxt;
    logic               l2_ready;
    logic               any_start;
    logic               l2_idle_cycle;

    function automatic logic [1:0] cu_code(input cu_state_t s);
        logic [1:0] code;
        code = 2'd0;
        case (s)
            CU_OFF:   code = 2'd0;
            CU_RST:   code = 2'd1;
            CU_RUN:   code = 2'd2;
            CU_DRAIN: code = 2'd2;
            CU_GATED: code = 2'd3;
            default:  code = 2'd0;
        endcase
        return code;
    endfunction

    assign l2_ready  = (l2_state == L2_ON);
    assign any_start = |cu_start_i;

    always_comb begin
        parked     = '0;
        parked_nxt = '0;
        for (int i = 0; i < NUM_CUS; i++) begin
            parked[i]     = (cu_state[i] == CU_OFF) || (cu_state[i] == CU_GATED);
            parked_nxt[i] = (cu_state_nxt[i] == CU_OFF) || (cu_state_nxt[i] == CU_GATED);
        end
    end

    // A pending start is never an idle cycle, so the L2 cannot gate on the
    // same edge a CU is let back into RUN.
    assign l2_idle_cycle = (&parked) && !l2_busy_i && !any_start;

    always_comb begin
        l2_state_nxt = l2_state;
        l2_cnt_nxt   = l2_cnt;
        case (l2_state)
            L2_OFF: begin
                if (any_start) begin
                    l2_state_nxt = L2_RST;
                    l2_cnt_nxt   = '0;
                end
            end
            L2_RST: begin
                if (l2_cnt == L2_RST_LAST) begin
                    l2_state_nxt = L2_ON;
                    l2_cnt_nxt   = '0;
                end else begin
                    l2_cnt_nxt = l2_cnt + 1'b1;
                end
            end
            L2_ON: begin
                if (!l2_idle_cycle) begin
                    l2_cnt_nxt = '0;
                end else if (l2_cnt >= L2_IDLE_LAST) begin
                    l2_state_nxt = L2_GATED;
                    l2_cnt_nxt   = '0;
                end else begin
                    l2_cnt_nxt = l2_cnt + 1'b1;
                end
            end
            L2_GATED: begin
                if (any_start) begin
                    l2_state_nxt = L2_ON;
                    l2_cnt_nxt   = '0;
                end
            end
            default: begin
                l2_state_nxt = L2_OFF;
                l2_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_CUS; i++) begin
            cu_state_nxt[i] = cu_state[i];
            cu_cnt_nxt[i]   = cu_cnt[i];
            case (cu_state[i])
                CU_OFF: begin
                    if (cu_start_i[i] && l2_ready) begin
                        cu_state_nxt[i] = CU_RST;
                        cu_cnt_nxt[i]   = '0;
                    end
                end
                CU_RST: begin
                    if (cu_cnt[i] == CU_RST_LAST) begin
                        cu_state_nxt[i] = CU_RUN;
                        cu_cnt_nxt[i]   = '0;
                    end else begin
                        cu_cnt_nxt[i] = cu_cnt[i] + 1'b1;
                    end
                end
                CU_RUN: begin
                    if (cu_sleep_req_i[i]) begin
                        cu_state_nxt[i] = CU_DRAIN;
                        cu_cnt_nxt[i]   = '0;
                    end
                end
                CU_DRAIN: begin
                    // Abort beats gating; an outstanding L2 request restarts the window.
                    if (cu_start_i[i] || !cu_sleep_req_i[i]) begin
                        cu_state_nxt[i] = CU_RUN;
                        cu_cnt_nxt[i]   = '0;
                    end else if (cu_delay_sleep_i[i]) begin
                        cu_cnt_nxt[i] = '0;
                    end else if (cu_cnt[i] >= CU_DRN_LAST) begin
                        cu_state_nxt[i] = CU_GATED;
                        cu_cnt_nxt[i]   = '0;
                    end else begin
                        cu_cnt_nxt[i] = cu_cnt[i] + 1'b1;
                    end
                end
                CU_GATED: begin
                    // A start that is still waiting for the L2 also blocks an off request.
                    if (cu_start_i[i]) begin
                        if (l2_ready) begin
                            cu_state_nxt[i] = CU_RUN;
                        end
                    end else if (cu_off_i[i]) begin
                        cu_state_nxt[i] = CU_OFF;
                    end
                end
                default: begin
                    cu_state_nxt[i] = CU_OFF;
                    cu_cnt_nxt[i]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            l2_state <= L2_OFF;
            l2_cnt   <= '0;
            for (int i = 0; i < NUM_CUS; i++) begin
                cu_state[i] <= CU_OFF;
                cu_cnt[i]   <= '0;
            end
        end else begin
            l2_state <= l2_state_nxt;
            l2_cnt   <= l2_cnt_nxt;
            for (int i = 0; i < NUM_CUS; i++) begin
                cu_state[i] <= cu_state_nxt[i];
                cu_cnt[i]   <= cu_cnt_nxt[i];
            end
        end
    end

    // Outputs are decoded from next state so they line up with the state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cu_clk_en_o <= '0;
            cu_rst_n_o  <= '0;
            cu_state_o  <= '0;
            l2_clk_en_o <= 1'b0;
            l2_rst_n_o  <= 1'b0;
            all_idle_o  <= 1'b1;
        end else begin
            for (int i = 0; i < NUM_CUS; i++) begin
                cu_clk_en_o[i]     <= (cu_state_nxt[i] == CU_RST) ||
                                      (cu_state_nxt[i] == CU_RUN) ||
                                      (cu_state_nxt[i] == CU_DRAIN);
                cu_rst_n_o[i]      <= (cu_state_nxt[i] == CU_RUN) ||
                                      (cu_state_nxt[i] == CU_DRAIN) ||
                                      (cu_state_nxt[i] == CU_GATED);
                cu_state_o[2*i +: 2] <= cu_code(cu_state_nxt[i]);
            end
            l2_clk_en_o <= (l2_state_nxt == L2_RST) || (l2_state_nxt == L2_ON);
            l2_rst_n_o  <= (l2_state_nxt == L2_ON) || (l2_state_nxt == L2_GATED);
            all_idle_o  <= (&parked_nxt) &&
                           ((l2_state_nxt == L2_OFF) || (l2_state_nxt == L2_GATED));
        end
    end

endmodule
